// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter
// Round-robin arbiter and sequencer that lets N_REQ requesters share one bank
// of DEPTH flip-flop words, each WIDTH bits wide. Each granted access performs
// one operation on one word: READ, D-LOAD, T-TOGGLE or JK-update. Every access
// runs the fixed sequence IDLE -> EXEC -> DONE -> IDLE, and only one access is
// in flight at a time.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   req     per-requester request, held high until its ack
//   op      per-requester op, slice i = op[2i+1:2i] (00 READ, 01 LOAD, 10 TOGGLE, 11 JK)
//   addr    per-requester word address, slice i = addr[i*ADDR_W +: ADDR_W]
//   wdata   per-requester D / T / J operand
//   kdata   per-requester K operand (JK only)
//   ack     one-cycle completion pulse, one-hot or zero
//   err     high together with ack when the completed address was >= DEPTH
//   rdata   pre-operation value of the addressed word, held between accesses
//   busy    high whenever the sequencer is not in IDLE
//   bank_q  all words, word n = bank_q[n*WIDTH +: WIDTH]
module ff_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int N_REQ = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [2*N_REQ-1:0]        op,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*WIDTH-1:0]    wdata,
    input  logic [N_REQ*WIDTH-1:0]    kdata,
    output logic [N_REQ-1:0]          ack,
    output logic                      err,
    output logic [WIDTH-1:0]          rdata,
    output logic                      busy,
    output logic [DEPTH*WIDTH-1:0]    bank_q
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0]  N_REQ_L = (PTR_W + 1)'(N_REQ);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_JK     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  win_reg;
    logic [1:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [WIDTH-1:0]  d_reg;
    logic [WIDTH-1:0]  k_reg;
    logic [N_REQ-1:0]  ack_reg;
    logic              err_reg;
    logic [WIDTH-1:0]  rdata_reg;

    // Per-requester views of the flat input buses.
    logic [1:0]        op_arr    [N_REQ];
    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [WIDTH-1:0]  wdata_arr [N_REQ];
    logic [WIDTH-1:0]  kdata_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req_split
            assign op_arr[gi]    = op[2*gi +: 2];
            assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
            assign kdata_arr[gi] = kdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: rotate req so the pointer position lands on bit 0,
    // take the lowest set bit of the rotated vector, then rotate back.
    // ------------------------------------------------------------------
    logic [2*N_REQ-1:0]          req_dbl;
    logic [N_REQ-1:0]            req_rot;
    logic [N_REQ:0]              seen;
    logic [N_REQ:0][PTR_W-1:0]   enc_chain;
    logic [PTR_W:0]              win_sum;
    logic [PTR_W-1:0]            win_comb;

    assign req_dbl = {req, req} >> ptr_reg;
    assign req_rot = req_dbl[N_REQ-1:0];
    assign seen[0] = 1'b0;
    assign enc_chain[0] = '0;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_prio
            logic hit;
            assign hit = req_rot[gi] & ~seen[gi];
            assign seen[gi+1] = seen[gi] | req_rot[gi];
            assign enc_chain[gi+1] = enc_chain[gi] | (hit ? PTR_W'(gi) : '0);
        end
    endgenerate

    // Both operands are below N_REQ, so one conditional subtract is the modulo.
    assign win_sum  = {1'b0, ptr_reg} + {1'b0, enc_chain[N_REQ]};
    assign win_comb = (win_sum >= N_REQ_L) ? PTR_W'(win_sum - N_REQ_L) : win_sum[PTR_W-1:0];

    logic [PTR_W:0]   ptr_inc;
    logic [PTR_W-1:0] ptr_next;

    assign ptr_inc  = {1'b0, win_reg} + (PTR_W + 1)'(1);
    assign ptr_next = (ptr_inc >= N_REQ_L) ? '0 : ptr_inc[PTR_W-1:0];

    // ------------------------------------------------------------------
    // Bank read mux and operation result. The OR-chain read yields zero for
    // an address that matches no word, which covers the out-of-range case.
    // ------------------------------------------------------------------
    logic [DEPTH:0][WIDTH-1:0] rd_chain;
    logic [WIDTH-1:0]          old_q;
    logic [WIDTH-1:0]          new_q;
    logic                      in_range;
    logic                      bank_we;

    assign rd_chain[0] = '0;
    assign old_q       = rd_chain[DEPTH];
    assign in_range    = ({1'b0, addr_reg} < DEPTH_L);
    assign bank_we     = (state_reg == EXEC) && in_range && (op_reg != OP_READ);

    always_comb begin
        new_q = old_q;
        case (op_reg)
            OP_LOAD:   new_q = d_reg;
            OP_TOGGLE: new_q = old_q ^ d_reg;
            OP_JK:     new_q = (d_reg & ~old_q) | (~k_reg & old_q);
            default:   new_q = old_q;
        endcase
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;
            logic             sel;

            assign sel = (addr_reg == ADDR_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (bank_we && sel) begin
                    word_reg <= new_q;
                end
            end

            assign rd_chain[gi+1] = rd_chain[gi] | (sel ? word_reg : '0);
            assign bank_q[gi*WIDTH +: WIDTH] = word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            win_reg   <= '0;
            op_reg    <= OP_READ;
            addr_reg  <= '0;
            d_reg     <= '0;
            k_reg     <= '0;
            ack_reg   <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            // ack/err are single-cycle pulses that cover only the DONE state.
            ack_reg <= '0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        win_reg  <= win_comb;
                        op_reg   <= op_arr[win_comb];
                        addr_reg <= addr_arr[win_comb];
                        d_reg    <= wdata_arr[win_comb];
                        k_reg    <= kdata_arr[win_comb];
                    end
                end
                EXEC: begin
                    rdata_reg <= in_range ? old_q : '0;
                    err_reg   <= ~in_range;
                    ack_reg   <= ONE_HOT0 << win_reg;
                    ptr_reg   <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign ack   = ack_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: doc/ff_bank_arbiter.md
Name: ff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of DEPTH flip-flop registers, each WIDTH bits wide, between N_REQ requesters.
- Each granted access performs one of four register operations on one word: read, D-load, T-toggle or JK-update.
- Sits between requester-side control logic and the shared state registers.
- Fixed three-state access sequence; at most one operation in flight.

Parameters:
- WIDTH, 8, bits per register word.
- DEPTH, 8, number of registers in the bank (2..256, not necessarily a power of two).
- N_REQ, 4, number of requesters (2..8).
- ADDR_W (localparam), $clog2(DEPTH), address width per requester.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request per requester; held high until its ack.
- op  in  2*N_REQ  per-requester op, slice i = op[2i+1:2i]: 00 READ, 01 LOAD, 10 TOGGLE, 11 JK.
- addr  in  N_REQ*ADDR_W  per-requester word address.
- wdata  in  N_REQ*WIDTH  per-requester D / T / J operand.
- kdata  in  N_REQ*WIDTH  per-requester K operand; used by JK only.
- ack  out  N_REQ  one-cycle completion pulse, one-hot or zero.
- err  out  1  high with ack when the completed access had addr >= DEPTH.
- rdata  out  WIDTH  pre-operation value of the addressed word; valid while any ack is high.
- busy  out  1  high in ARB-committed EXEC and DONE states.
- bank_q  out  DEPTH*WIDTH  all register contents; word n = bank_q[n*WIDTH +: WIDTH].

Behaviour:
- Reset (async on rst_n low, all registered):
  - bank words 0, ack 0, err 0, rdata 0, busy 0.
  - state IDLE, round-robin pointer 0, latched grant index 0.
  - Reset during EXEC or DONE aborts the access: no bank update, no ack.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - If req is nonzero, pick the winner: the first i with req[i]=1, searching pointer, pointer+1, ... mod N_REQ.
  - Latch the winner index, its op, addr, wdata and kdata; go to EXEC.
  - Otherwise stay in IDLE.
  - Inputs are sampled only at this edge; later changes are ignored.
- EXEC, at the clock edge (latched word at address a, old value q):
  - rdata <= q.
  - READ: bank unchanged.
  - LOAD: q <= d.
  - TOGGLE: q <= q ^ d.
  - JK: q <= (j & ~q) | (~k & q), bitwise.
  - Out-of-range address: no bank write, rdata <= 0, err <= 1.
  - ack[winner] <= 1; pointer <= (winner+1) mod N_REQ; go to DONE.
- DONE:
  - ack and err high for exactly this cycle; cleared at the next edge.
  - Go to IDLE.
  - The requester must drop req at this edge; a req still high is treated as a new request in IDLE.
- Timing:
  - Latency: req high in IDLE -> ack 2 cycles later.
  - Throughput: one access per 3 cycles.
  - bank_q reflects the update from the cycle after the EXEC edge, i.e. during DONE.
- busy = state != IDLE.
- rdata holds its value outside ack cycles; it changes only in EXEC.
- Simultaneous requests: exactly one grant per access; losers keep req high and are served in later rounds in round-robin order.
- No starvation: a continuously asserting requester is granted within N_REQ accesses.
- Addresses are unsigned; no wrap-around; out-of-range handled as above.

Test Plan:
- Reset with rst_n low mid-EXEC (LOAD 0xAA to word 3 in flight) -> bank_q all 0, no ack, busy 0 immediately, without waiting for a clock edge.
- Req[1] LOAD addr 2 wdata 0x5A, then req[1] READ addr 2 -> first ack[1] at cycle+2 with rdata 0x00; second ack with rdata 0x5A; bank_q word 2 = 0x5A.
- Word 4 = 0xF0, then TOGGLE wdata 0x3C -> rdata 0xF0, word 4 = 0xCC. Then JK j=0x0F, k=0xC0 -> word 4 = 0x0F.
- req = 4'b1111 held, each requester dropping req on its own ack -> acks in order 0,1,2,3. Then with only req[0] and req[2] re-raised, pointer at 0 -> grant 0 then 2.
- With DEPTH=6 instance, LOAD addr 7 wdata 0xFF -> ack with err=1, rdata 0, bank_q unchanged.
- Requester holds req through DONE -> re-granted as a new access. Same op repeated: a LOAD writes twice with the same value, a TOGGLE toggles twice and restores the original word.
